// File: rtl/synctrig_seq_ctrl.sv
// synctrig_seq_ctrl: trigger-driven pulse sequencer sharing one timer across all channels.
// Optional per-channel feedback check is built when SYNCTRIG_FB_CHECK_EN is defined.
module synctrig_seq_ctrl #(
  parameter int CH_NUM                  = 8,
  parameter int PULSEWIDTH_CNT_BITWIDTH = 24,
  parameter int TIMER_BITWIDTH          = 32
) (
  input  logic                                  io_clk,
  input  logic                                  io_rst,
  input  logic                                  cfg_en,
  input  logic [CH_NUM-1:0]                     cfg_ch_mask,
  input  logic [CH_NUM*TIMER_BITWIDTH-1:0]      cfg_delay,
  input  logic [CH_NUM*PULSEWIDTH_CNT_BITWIDTH-1:0] cfg_width,
  input  logic [TIMER_BITWIDTH-1:0]             cfg_fb_timeout,
  input  logic                                  io_trig_in,
  input  logic [CH_NUM-1:0]                     io_fb_in,
  output logic [CH_NUM-1:0]                     io_pulse_out,
  output logic                                  io_busy,
  output logic                                  io_done,
  output logic                                  io_overrun,
  output logic [CH_NUM-1:0]                     io_fb_ok,
  output logic                                  io_fb_err
);

  // state     | meaning
  // S_IDLE    | waiting for trigger; start flag held here for one cycle
  // S_DELAY   | pre-pulse delay of current channel
  // S_PULSE   | current channel pulse high
  // S_FB_WAIT | waiting for current channel feedback
  // S_DONE    | one-cycle end of sequence
  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_PULSE, S_FB_WAIT, S_DONE} state_t;

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int TW   = TIMER_BITWIDTH;
  localparam int PW   = PULSEWIDTH_CNT_BITWIDTH;

  function automatic logic [CH_W-1:0] f_lsb(input logic [CH_NUM-1:0] m);
    f_lsb = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) if (m[i]) f_lsb = CH_W'(i);
  endfunction

  function automatic logic [CH_NUM-1:0] f_onehot(input logic [CH_W-1:0] idx);
    f_onehot = '0;
    for (int i = 0; i < CH_NUM; i++) if (CH_W'(i) == idx) f_onehot[i] = 1'b1;
  endfunction

  function automatic logic [TW-1:0] f_delay(input logic [CH_NUM*TW-1:0] v, input logic [CH_W-1:0] idx);
    f_delay = '0;
    for (int i = 0; i < CH_NUM; i++) if (CH_W'(i) == idx) f_delay = v[i*TW +: TW];
  endfunction

  function automatic logic [PW-1:0] f_width(input logic [CH_NUM*PW-1:0] v, input logic [CH_W-1:0] idx);
    f_width = '0;
    for (int i = 0; i < CH_NUM; i++) if (CH_W'(i) == idx) f_width = v[i*PW +: PW];
  endfunction

  state_t              r_state, w_state_nx, w_chan_entry;
  logic                r_trig_q, r_start, r_overrun;
  logic [CH_NUM-1:0]   r_pend, r_pulse;
  logic [CH_NUM*TW-1:0] r_sh_delay;
  logic [CH_NUM*PW-1:0] r_sh_width;
  logic [TW-1:0]       r_cnt;

  logic                w_edge, w_start, w_cnt_clr, w_pend_upd;
  logic [CH_W-1:0]     w_ch, w_ch_nx;
  logic [CH_NUM-1:0]   w_pend_rest, w_pend_sel, w_pend_nx;
  logic [TW-1:0]       w_d_cur, w_d_nxt, w_w_last;
  logic [PW-1:0]       w_w_cur;

  assign w_edge  = io_trig_in & ~r_trig_q;
  assign w_start = w_edge & cfg_en & (r_state == S_IDLE) & ~r_start;

  // r_pend holds the channels not yet finished; its lowest bit is the active channel
  assign w_ch        = f_lsb(r_pend);
  assign w_pend_rest = r_pend & ~f_onehot(w_ch);
  assign w_pend_sel  = (r_state == S_IDLE) ? r_pend : w_pend_rest;
  assign w_d_cur     = f_delay(r_sh_delay, w_ch);
  assign w_d_nxt     = f_delay(r_sh_delay, f_lsb(w_pend_sel));
  assign w_w_cur     = f_width(r_sh_width, w_ch);
  assign w_w_last    = (w_w_cur == '0) ? '0 : TW'(w_w_cur - PW'(1));
  assign w_chan_entry = (w_pend_sel == '0) ? S_DONE :
                        (w_d_nxt == '0)    ? S_PULSE : S_DELAY;

`ifdef SYNCTRIG_FB_CHECK_EN
  logic [TW-1:0]     r_sh_tmo, w_t_last;
  logic [CH_NUM-1:0] r_fb_ok;
  logic              r_fb_err, w_fb_hit, w_fb_tmo;

  assign w_t_last = (r_sh_tmo == '0) ? '0 : r_sh_tmo - TW'(1);
  assign w_fb_hit = (r_state == S_FB_WAIT) & cfg_en & io_fb_in[w_ch];
  assign w_fb_tmo = (r_state == S_FB_WAIT) & cfg_en & ~io_fb_in[w_ch] & (r_cnt == w_t_last);
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_clr  = 1'b0;
    w_pend_upd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_state_nx = w_chan_entry;
          w_cnt_clr  = 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == w_d_cur - TW'(1)) begin
          w_state_nx = S_PULSE;
          w_cnt_clr  = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt == w_w_last) begin
`ifdef SYNCTRIG_FB_CHECK_EN
          w_state_nx = S_FB_WAIT;
`else
          w_state_nx = w_chan_entry;
          w_pend_upd = 1'b1;
`endif
          w_cnt_clr = 1'b1;
        end
      end
      S_FB_WAIT: begin
`ifdef SYNCTRIG_FB_CHECK_EN
        if (w_fb_hit || w_fb_tmo) begin
          w_state_nx = w_chan_entry;
          w_pend_upd = 1'b1;
          w_cnt_clr  = 1'b1;
        end
`else
        w_state_nx = S_IDLE;
`endif
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (!cfg_en && (r_state != S_IDLE)) begin
      w_state_nx = S_IDLE;
      w_pend_upd = 1'b0;
    end
  end

  assign w_pend_nx = w_start    ? cfg_ch_mask :
                     w_pend_upd ? w_pend_rest : r_pend;
  assign w_ch_nx   = f_lsb(w_pend_nx);

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_state    <= S_IDLE;
      r_trig_q   <= 1'b0;
      r_start    <= 1'b0;
      r_overrun  <= 1'b0;
      r_pend     <= '0;
      r_pulse    <= '0;
      r_cnt      <= '0;
      r_sh_delay <= '0;
      r_sh_width <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_trig_q <= io_trig_in;
      r_start  <= w_start;
      r_pend   <= w_pend_nx;
      r_cnt    <= (w_cnt_clr || (w_state_nx == S_IDLE)) ? '0 : r_cnt + TW'(1);
      r_pulse  <= (w_state_nx == S_PULSE) ? f_onehot(w_ch_nx) : '0;
      if (w_start) begin
        r_sh_delay <= cfg_delay;
        r_sh_width <= cfg_width;
        r_overrun  <= 1'b0;
      end else if (w_edge && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef SYNCTRIG_FB_CHECK_EN
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      r_sh_tmo <= '0;
      r_fb_ok  <= '0;
      r_fb_err <= 1'b0;
    end else if (w_start) begin
      r_sh_tmo <= cfg_fb_timeout;
      r_fb_ok  <= '0;
      r_fb_err <= 1'b0;
    end else begin
      if (w_fb_hit) r_fb_ok  <= r_fb_ok | f_onehot(w_ch);
      if (w_fb_tmo) r_fb_err <= 1'b1;
    end
  end

  assign io_fb_ok  = r_fb_ok;
  assign io_fb_err = r_fb_err;
`else
  logic w_unused_fb;
  assign w_unused_fb = ^{io_fb_in, cfg_fb_timeout};
  assign io_fb_ok    = '0;
  assign io_fb_err   = 1'b0;
`endif

  assign io_pulse_out = r_pulse;
  assign io_busy      = (r_state != S_IDLE);
  assign io_done      = (r_state == S_DONE);
  assign io_overrun   = r_overrun;

endmodule
